// File: rtl/io_key_in_port.sv
// io_key_in_port: four active-low push-buttons turned into two wrapping
// operand words plus latched press events, read back over a registered port.
// Each key passes a two-flop synchroniser, a counter-based debouncer and a
// falling-edge detector. Presses step the operands and latch event flags;
// a status read clears the flags.
module io_key_in_port #(
  parameter int OPW             = 5,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 20
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  set,
  input  logic        rd_en,
  input  logic [1:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic [31:0] in_port0,
  output logic [31:0] in_port1,
  output logic [3:0]  key_state,
  output logic        event_pending
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]       sync_p0;
  logic [3:0]       sync_p1;
  logic [3:0]       deb_p2;
  logic [CNT_W-1:0] cnt_p2 [4];
  logic [OPW-1:0]   op0_p2;
  logic [OPW-1:0]   op1_p2;
  logic [3:0]       flag_p2;

  logic [3:0]       deb_next;
  logic [CNT_W-1:0] cnt_next [4];
  logic [3:0]       press;
  logic [3:0]       flag_next;
  logic             status_rd;

  // Modulo-2^OPW step: inc and dec together cancel out.
  function automatic logic [OPW-1:0] op_step(input logic [OPW-1:0] v,
                                             input logic inc,
                                             input logic dec);
    logic [OPW-1:0] r;
    r = v;
    if (inc && !dec) r = v + OPW'(1);
    else if (dec && !inc) r = v - OPW'(1);
    return r;
  endfunction

  // Zero-extend an operand onto the 32-bit CPU bus.
  function automatic logic [31:0] zext(input logic [OPW-1:0] v);
    return {{(32 - OPW){1'b0}}, v};
  endfunction

  // Read multiplexer over pre-update state.
  function automatic logic [31:0] rd_mux(input logic [1:0]     addr,
                                         input logic [OPW-1:0] o0,
                                         input logic [OPW-1:0] o1,
                                         input logic [3:0]     lvl,
                                         input logic [3:0]     flg);
    logic [31:0] r;
    case (addr)
      2'd0:    r = zext(o0);
      2'd1:    r = zext(o1);
      2'd2:    r = {24'b0, lvl, flg};
      default: r = 32'b0;
    endcase
    return r;
  endfunction

  // ---- stage 0/1: two-flop synchroniser, idle level is 1 ----
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_p0 <= 4'b1111;
      sync_p1 <= 4'b1111;
    end else begin
      sync_p0 <= set;
      sync_p1 <= sync_p0;
    end
  end

  // Debounce decision: accept a change after DEBOUNCE_CYCLES differing samples.
  always_comb begin
    deb_next = deb_p2;
    cnt_next = cnt_p2;
    for (int i = 0; i < 4; i++) begin
      if (sync_p1[i] == deb_p2[i]) begin
        cnt_next[i] = '0;
      end else if (cnt_p2[i] == CNT_LAST) begin
        deb_next[i] = sync_p1[i];
        cnt_next[i] = '0;
      end else begin
        cnt_next[i] = cnt_p2[i] + CNT_W'(1);
      end
    end
  end

  // A press is a debounced 1->0 in this edge; a status read clears old flags
  // but a press landing in the same edge still survives.
  always_comb begin
    press     = deb_p2 & ~deb_next;
    status_rd = rd_en && (rd_addr == 2'd2);
    flag_next = (status_rd ? 4'b0000 : flag_p2) | press;
  end

  // ---- stage 2: debounced levels, counters, operands, flags ----
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      deb_p2  <= 4'b1111;
      for (int i = 0; i < 4; i++) cnt_p2[i] <= '0;
      op0_p2  <= '0;
      op1_p2  <= '0;
      flag_p2 <= 4'b0000;
    end else begin
      deb_p2  <= deb_next;
      for (int i = 0; i < 4; i++) cnt_p2[i] <= cnt_next[i];
      op0_p2  <= op_step(op0_p2, press[0], press[1]);
      op1_p2  <= op_step(op1_p2, press[2], press[3]);
      flag_p2 <= flag_next;
    end
  end

  // ---- read port: registered, holds when idle ----
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_data <= 32'b0;
    end else if (rd_en) begin
      rd_data <= rd_mux(rd_addr, op0_p2, op1_p2, deb_p2, flag_p2);
    end
  end

  assign in_port0      = zext(op0_p2);
  assign in_port1      = zext(op1_p2);
  assign key_state     = deb_p2;
  assign event_pending = |flag_p2;

endmodule
